// File: rtl/input_conditioner_3in.sv
// input_conditioner_3in: synchronizes and debounces three raw lines as one vector, committing only stable values.
module input_conditioner_3in #(
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in1,
  input  logic                raw_in2,
  input  logic                raw_in3,
  input  logic                hold,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                settled,
  output logic                changed,
  output logic [GLITCH_W-1:0] glitch_cnt
);
  localparam int CW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  typedef enum logic {STABLE, SETTLING} state_t;
  state_t state, state_n;
  logic [2:0] sync1, s, c, k, c_n, k_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GLITCH_W-1:0] glitch_n, glitch_inc;
  logic changed_n;
  assign glitch_inc = &glitch_cnt ? glitch_cnt : glitch_cnt + 1'b1;
  assign {in1, in2, in3} = c;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      s <= '0;
      state <= STABLE;
      c <= '0;
      k <= '0;
      cnt <= '0;
      glitch_cnt <= '0;
      changed <= 1'b0;
      settled <= 1'b1;
    end else begin
      sync1 <= {raw_in1, raw_in2, raw_in3};
      s <= sync1;
      state <= state_n;
      c <= c_n;
      k <= k_n;
      cnt <= cnt_n;
      glitch_cnt <= glitch_n;
      changed <= changed_n;
      settled <= state_n == STABLE;
    end
  // Priority: abort, retarget, count, hold at the last count, commit.
  always_comb begin
    state_n = state;
    c_n = c;
    k_n = k;
    cnt_n = cnt;
    glitch_n = glitch_cnt;
    changed_n = 1'b0;
    if (state == STABLE) begin
      if (s != c) begin
        k_n = s;
        cnt_n = CW'(1);
        state_n = SETTLING;
      end
    end else if (s != k) begin
      glitch_n = glitch_inc;
      state_n = s == c ? STABLE : SETTLING;
      k_n = s == c ? k : s;
      cnt_n = s == c ? cnt : CW'(1);
    end else if (cnt < LAST) begin
      cnt_n = cnt + 1'b1;
    end else if (!hold) begin
      c_n = k;
      changed_n = 1'b1;
      state_n = STABLE;
    end
  end
endmodule
